// File: rtl/fir_mac_bank_if.sv
// fir_mac_bank_if: sample, coefficient and result bus of the shared FIR MAC bank.
//   master (producer side): drives sample_*, bank_en, coef_*, err_clr
//   slave  (fir_mac_bank) : drives sample_ready, out_*, overrun, coef_err
interface fir_mac_bank_if #(
  parameter int WORD_LENGTH = 16,
  parameter int TAPS        = 32,
  parameter int CHANNELS    = 2,
  parameter int BANKS       = 3
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TW = $clog2(TAPS);

  logic                          sample_valid;
  logic [CW-1:0]                 sample_ch;
  logic signed [WORD_LENGTH-1:0] sample_in;
  logic [BANKS-1:0]              bank_en;
  logic                          sample_ready;
  logic                          coef_we;
  logic [BW-1:0]                 coef_bank;
  logic [TW-1:0]                 coef_addr;
  logic signed [WORD_LENGTH-1:0] coef_data;
  logic                          err_clr;
  logic                          out_valid;
  logic [CW-1:0]                 out_ch;
  logic [BW-1:0]                 out_bank;
  logic signed [WORD_LENGTH-1:0] out_data;
  logic                          overrun;
  logic                          coef_err;

  modport master (
    output sample_valid, sample_ch, sample_in, bank_en,
    output coef_we, coef_bank, coef_addr, coef_data, err_clr,
    input  sample_ready, out_valid, out_ch, out_bank, out_data, overrun, coef_err
  );

  modport slave (
    input  sample_valid, sample_ch, sample_in, bank_en,
    input  coef_we, coef_bank, coef_addr, coef_data, err_clr,
    output sample_ready, out_valid, out_ch, out_bank, out_data, overrun, coef_err
  );
endinterface

// File: rtl/fir_mac_bank.sv
// fir_mac_bank: time-multiplexed FIR bank. One MAC serves CHANNELS delay lines
// and BANKS loadable coefficient sets, one tap per clock.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : fir_mac_bank_if.slave (sample in, coefficient load, result out,
//             sticky overrun / coef_err flags)
// Per accepted sample each enabled bank takes TAPS MAC cycles plus one EMIT
// cycle; banks run lowest index first.
module fir_mac_bank #(
  parameter int WORD_LENGTH = 16,
  parameter int TAPS        = 32,
  parameter int CHANNELS    = 2,
  parameter int BANKS       = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fir_mac_bank_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TW = $clog2(TAPS);
  localparam int PW = 2 * WORD_LENGTH;
  localparam int AW = PW + TW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WORD_LENGTH+1){1'b0}}, {(WORD_LENGTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WORD_LENGTH+1){1'b1}}, {(WORD_LENGTH-1){1'b0}}};

  logic [1:0]                    r_state;
  logic signed [WORD_LENGTH-1:0] r_dl   [CHANNELS][TAPS];
  logic signed [WORD_LENGTH-1:0] r_coef [BANKS][TAPS];
  logic [TW-1:0]                 r_wptr [CHANNELS];
  logic [CW-1:0]                 r_ch;
  logic [BW-1:0]                 r_bank;
  logic [BANKS-1:0]              r_pend;   // enabled banks still to run after r_bank
  logic [TW-1:0]                 r_base;   // slot holding x[n] of the current sample
  logic [TW-1:0]                 r_k;
  logic signed [AW-1:0]          r_acc;
  logic                          r_overrun;
  logic                          r_coef_err;

  function automatic logic [BW-1:0] f_lowest(input logic [BANKS-1:0] m);
    f_lowest = '0;
    for (int i = BANKS - 1; i >= 0; i--)
      if (m[i]) f_lowest = BW'(i);
  endfunction

  // Range guards only exist when the index field can encode illegal values.
  logic w_ch_ok, w_cbank_ok, w_caddr_ok;
  generate
    if (CHANNELS == (1 << CW)) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_part
      assign w_ch_ok = (bus.sample_ch < CW'(CHANNELS));
    end
    if (BANKS == (1 << BW)) begin : g_bk_full
      assign w_cbank_ok = 1'b1;
    end else begin : g_bk_part
      assign w_cbank_ok = (bus.coef_bank < BW'(BANKS));
    end
    if (TAPS == (1 << TW)) begin : g_tp_full
      assign w_caddr_ok = 1'b1;
    end else begin : g_tp_part
      assign w_caddr_ok = (bus.coef_addr < TW'(TAPS));
    end
  endgenerate

  logic w_last, w_ready, w_accept, w_start, w_emit;
  assign w_last   = (r_pend == '0);
  // Ready in the final EMIT so the next sample can follow without a gap.
  assign w_ready  = (r_state == S_IDLE) || ((r_state == S_EMIT) && w_last);
  assign w_accept = bus.sample_valid && w_ready && w_ch_ok;
  assign w_start  = w_accept && (bus.bank_en != '0);
  assign w_emit   = (r_state == S_EMIT);

  // x[n-k] sits k slots behind r_base, wrapping modulo TAPS.
  logic [TW:0]   w_diff, w_wrap;
  logic [TW-1:0] w_idx;
  assign w_diff = {1'b0, r_base} - {1'b0, r_k};
  assign w_wrap = w_diff + (TW+1)'(TAPS);
  assign w_idx  = w_diff[TW] ? w_wrap[TW-1:0] : w_diff[TW-1:0];

  logic signed [WORD_LENGTH-1:0] w_c, w_x;
  logic signed [PW-1:0]          w_cx, w_xx, w_prod;
  logic signed [AW-1:0]          w_pext, w_acc_base, w_acc_nxt, w_shr;
  logic signed [WORD_LENGTH-1:0] w_sat;

  assign w_c        = r_coef[r_bank][r_k];
  assign w_x        = r_dl[r_ch][w_idx];
  assign w_cx       = {{WORD_LENGTH{w_c[WORD_LENGTH-1]}}, w_c};
  assign w_xx       = {{WORD_LENGTH{w_x[WORD_LENGTH-1]}}, w_x};
  assign w_prod     = w_cx * w_xx;
  assign w_pext     = {{TW{w_prod[PW-1]}}, w_prod};
  // Tap 0 restarts the sum, so each bank starts from a clean accumulator.
  assign w_acc_base = (r_k == '0) ? '0 : r_acc;
  assign w_acc_nxt  = w_acc_base + w_pext;
  assign w_shr      = r_acc >>> (WORD_LENGTH - 1);

  always_comb begin
    w_sat = w_shr[WORD_LENGTH-1:0];
    if (w_shr > SAT_MAX)      w_sat = SAT_MAX[WORD_LENGTH-1:0];
    else if (w_shr < SAT_MIN) w_sat = SAT_MIN[WORD_LENGTH-1:0];
  end

  // Delay lines: written on every accepted sample, even with an empty bank mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) r_dl[c][t] <= '0;
      end
    end else if (w_accept) begin
      r_dl[bus.sample_ch][r_wptr[bus.sample_ch]] <= bus.sample_in;
      r_wptr[bus.sample_ch] <= (r_wptr[bus.sample_ch] == TW'(TAPS - 1)) ? '0
                                                                         : r_wptr[bus.sample_ch] + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < BANKS; b++)
        for (int t = 0; t < TAPS; t++) r_coef[b][t] <= '0;
    end else if (bus.coef_we && w_ready && w_cbank_ok && w_caddr_ok) begin
      r_coef[bus.coef_bank][bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_bank  <= '0;
      r_pend  <= '0;
      r_base  <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else begin
      if (w_accept) begin
        r_ch   <= bus.sample_ch;
        r_base <= r_wptr[bus.sample_ch];
      end
      case (r_state)
        S_MAC: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + 1'b1;
          if (r_k == TW'(TAPS - 1)) r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (!w_last) begin
            r_bank  <= f_lowest(r_pend);
            r_pend  <= r_pend & (r_pend - 1'b1);
            r_k     <= '0;
            r_state <= S_MAC;
          end else if (w_start) begin
            r_bank  <= f_lowest(bus.bank_en);
            r_pend  <= bus.bank_en & (bus.bank_en - 1'b1);
            r_k     <= '0;
            r_state <= S_MAC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (w_start) begin
            r_bank  <= f_lowest(bus.bank_en);
            r_pend  <= bus.bank_en & (bus.bank_en - 1'b1);
            r_k     <= '0;
            r_state <= S_MAC;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Sticky flags: a new error in the clearing cycle keeps the flag set.
  logic w_ovr_evt, w_cerr_evt;
  assign w_ovr_evt  = bus.sample_valid && (!w_ready || !w_ch_ok);
  assign w_cerr_evt = bus.coef_we && !w_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun  <= 1'b0;
      r_coef_err <= 1'b0;
    end else begin
      r_overrun  <= w_ovr_evt  || (r_overrun  && !bus.err_clr);
      r_coef_err <= w_cerr_evt || (r_coef_err && !bus.err_clr);
    end
  end

  assign bus.sample_ready = w_ready;
  assign bus.out_valid    = w_emit;
  assign bus.out_ch       = w_emit ? r_ch   : '0;
  assign bus.out_bank     = w_emit ? r_bank : '0;
  assign bus.out_data     = w_emit ? w_sat  : '0;
  assign bus.overrun      = r_overrun;
  assign bus.coef_err     = r_coef_err;
endmodule

// File: tb/tb_fir_mac_bank.sv
module tb_fir_mac_bank;
  localparam int WL   = 16;
  localparam int TAPS = 32;
  localparam int CH   = 2;
  localparam int NB   = 3;
  localparam int PER  = TAPS + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_mac_bank_if #(.WORD_LENGTH(WL), .TAPS(TAPS), .CHANNELS(CH), .BANKS(NB)) bus ();

  fir_mac_bank #(.WORD_LENGTH(WL), .TAPS(TAPS), .CHANNELS(CH), .BANKS(NB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_out;

  // Reference: coefficient table plus per-channel history, newest first.
  int m_coef [NB][TAPS];
  int m_hist [CH][$];

  function automatic int sx16(input int v);
    logic signed [15:0] s;
    s = v[15:0];
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < TAPS; k++) m_coef[b][k] = 0;
    for (int c = 0; c < CH; c++) m_hist[c].delete();
  endtask

  task automatic model_push(input int ch, input int d);
    m_hist[ch].push_front(sx16(d));
    if (m_hist[ch].size() > TAPS) void'(m_hist[ch].pop_back());
  endtask

  function automatic int model_out(input int ch, input int b);
    longint acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++)
      if (k < m_hist[ch].size()) acc += longint'(m_coef[b][k]) * longint'(m_hist[ch][k]);
    acc = acc >>> (WL - 1);
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  // Caller sits 1 time unit after a rising edge with the DUT ready.
  task automatic load_coef(input int b, input int k, input int v);
    bus.coef_we   = 1'b1;
    bus.coef_bank = 2'(b);
    bus.coef_addr = 5'(k);
    bus.coef_data = v[15:0];
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    m_coef[b][k] = sx16(v);
  endtask

  // Offer one sample and follow it to the end of its last result. With
  // inject_at > 0 a sample and a coefficient write are forced in that cycle
  // (relative to acceptance); both must be dropped. With chain=1 the task
  // returns inside the final EMIT cycle so the next sample follows at once.
  task automatic run_sample(input int ch, input int d, input logic [NB-1:0] mask,
                            input int inject_at, input bit chain);
    int exp_data[$];
    int exp_bank[$];
    int nb, last;
    model_push(ch, d);
    for (int b = 0; b < NB; b++)
      if (mask[b]) begin
        exp_bank.push_back(b);
        exp_data.push_back(model_out(ch, b));
      end
    nb = exp_bank.size();
    bus.sample_valid = 1'b1;
    bus.sample_ch    = 1'(ch);
    bus.sample_in    = d[15:0];
    bus.bank_en      = mask;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    last = (nb == 0) ? 2 * PER : nb * PER;
    for (int off = 1; off <= last; off++) begin
      bit ev, er;
      int j;
      if (off == inject_at) begin
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 1'(ch);
        bus.sample_in    = 16'h1234;
        bus.coef_we      = 1'b1;
        bus.coef_bank    = 2'd0;
        bus.coef_addr    = 5'd0;
        bus.coef_data    = 16'h7000;
      end
      @(negedge clk);
      ev = (nb != 0) && ((off % PER) == 0);
      er = (nb == 0) || (off == last);
      j  = off / PER - 1;
      n_vec++;
      if (bus.out_valid !== ev) begin
        n_err++;
        $display("FAIL out_valid ch=%0d off=%0d got %b exp %b", ch, off, bus.out_valid, ev);
      end
      n_vec++;
      if (bus.sample_ready !== er) begin
        n_err++;
        $display("FAIL sample_ready ch=%0d off=%0d got %b exp %b", ch, off, bus.sample_ready, er);
      end
      if (ev && bus.out_valid === 1'b1) begin
        last_out = bus.out_data;
        n_vec++;
        if (bus.out_bank !== 2'(exp_bank[j]) || bus.out_ch !== 1'(ch)) begin
          n_err++;
          $display("FAIL out_tag off=%0d got bank %0d ch %0d exp bank %0d ch %0d",
                   off, bus.out_bank, bus.out_ch, exp_bank[j], ch);
        end
        n_vec++;
        if (bus.out_data !== 16'(exp_data[j])) begin
          n_err++;
          $display("FAIL out_data ch=%0d bank=%0d got %h exp %h", ch, exp_bank[j],
                   bus.out_data, 16'(exp_data[j]));
        end
      end
      if (off < last || !chain) begin
        @(posedge clk); #1;
      end
      if (off == inject_at) begin
        bus.sample_valid = 1'b0;
        bus.coef_we      = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.sample_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 ||
        bus.out_ch !== 1'b0 || bus.out_bank !== 2'd0 || bus.overrun !== 1'b0 || bus.coef_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state rdy=%b vld=%b data=%h ch=%b bank=%0d ovr=%b cerr=%b exp rdy=1 rest 0",
               bus.sample_ready, bus.out_valid, bus.out_data, bus.out_ch, bus.out_bank,
               bus.overrun, bus.coef_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_impulse();
    load_coef(0, 0, 16'h4000);
    load_coef(0, 1, 16'h2000);
    run_sample(0, 16'h1000, 3'b001, 0, 1'b0);
    n_vec++;
    if (last_out !== 16'h0800) begin n_err++; $display("FAIL impulse0 got %h exp 0800", last_out); end
    run_sample(0, 16'h0000, 3'b001, 0, 1'b0);
    n_vec++;
    if (last_out !== 16'h0400) begin n_err++; $display("FAIL impulse1 got %h exp 0400", last_out); end
    run_sample(0, 16'h0000, 3'b001, 0, 1'b0);
    n_vec++;
    if (last_out !== 16'h0000) begin n_err++; $display("FAIL impulse2 got %h exp 0000", last_out); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < TAPS; k++) load_coef(1, k, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) run_sample(0, 16'h7FFF, 3'b010, 0, 1'b0);
    n_vec++;
    if (last_out !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos got %h exp 7fff", last_out); end
    for (int i = 0; i < TAPS; i++) run_sample(0, 16'h8000, 3'b010, 0, 1'b0);
    n_vec++;
    if (last_out !== 16'h8000) begin n_err++; $display("FAIL sat_neg got %h exp 8000", last_out); end
  endtask

  task automatic test_channel_iso();
    run_sample(0, 16'h1000, 3'b001, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_sample(1, 16'h0000, 3'b001, 0, 1'b0);
      n_vec++;
      if (last_out !== 16'h0000) begin n_err++; $display("FAIL ch1_iso got %h exp 0000", last_out); end
    end
    run_sample(0, 16'h0000, 3'b001, 0, 1'b0);
    n_vec++;
    if (last_out !== 16'h0400) begin n_err++; $display("FAIL ch0_c1 got %h exp 0400", last_out); end
  endtask

  task automatic test_bank_mask();
    load_coef(2, 0, 16'hC000);
    load_coef(2, 3, 16'h1111);
    run_sample(1, 16'h2345, 3'b101, 0, 1'b0);
    run_sample(1, 16'h7000, 3'b000, 0, 1'b0);
    run_sample(1, 16'h0100, 3'b111, 0, 1'b0);
  endtask

  task automatic test_overrun();
    run_sample(0, 16'h0800, 3'b001, 5, 1'b0);
    n_vec++;
    if (bus.overrun !== 1'b1 || bus.coef_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_set got ovr=%b cerr=%b exp 1 1", bus.overrun, bus.coef_err);
    end
    // Follow-up result reveals a leaked sample or coefficient write.
    run_sample(0, 16'h0400, 3'b001, 0, 1'b0);
    n_vec++;
    if (bus.overrun !== 1'b1 || bus.coef_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky got ovr=%b cerr=%b exp 1 1", bus.overrun, bus.coef_err);
    end
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    n_vec++;
    if (bus.overrun !== 1'b0 || bus.coef_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr got ovr=%b cerr=%b exp 0 0", bus.overrun, bus.coef_err);
    end
  endtask

  task automatic test_back_to_back();
    run_sample(1, 16'h0321, 3'b011, 0, 1'b1);
    run_sample(0, 16'hF000, 3'b100, 0, 1'b1);
    run_sample(1, 16'h0777, 3'b001, 0, 1'b0);
  endtask

  task automatic test_reset_mid_mac();
    bus.sample_valid = 1'b1;
    bus.sample_ch    = 1'b0;
    bus.sample_in    = 16'h1000;
    bus.bank_en      = 3'b111;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.sample_ready !== 1'b1 || bus.out_data !== 16'h0) begin
      n_err++;
      $display("FAIL mid_reset got vld=%b rdy=%b data=%h exp 0 1 0000",
               bus.out_valid, bus.sample_ready, bus.out_data);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Cleared coefficients: any sample must filter to zero.
    run_sample(1, 16'h7FFF, 3'b111, 0, 1'b0);
    n_vec++;
    if (last_out !== 16'h0000) begin n_err++; $display("FAIL coef_cleared got %h exp 0000", last_out); end
    test_impulse();
  endtask

  task automatic test_random();
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < TAPS; k++) load_coef(b, k, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 10; i++) begin
      int ch, d;
      logic [NB-1:0] m;
      bit ch_n;
      ch   = int'($urandom_range(0, CH - 1));
      d    = int'($urandom_range(0, 65535));
      m    = 3'($urandom_range(0, 7));
      ch_n = (i < 9) && ($urandom_range(0, 1) == 1) && (m != 3'b000);
      run_sample(ch, d, m, 0, ch_n);
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_ch    = '0;
    bus.sample_in    = '0;
    bus.bank_en      = '0;
    bus.coef_we      = 1'b0;
    bus.coef_bank    = '0;
    bus.coef_addr    = '0;
    bus.coef_data    = '0;
    bus.err_clr      = 1'b0;
    last_out         = '0;
    model_reset();
    test_reset();
    test_impulse();
    test_saturation();
    test_channel_iso();
    test_bank_mask();
    test_overrun();
    test_back_to_back();
    test_reset_mid_mac();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_mac_bank.md
Name: fir_mac_bank

Overview:
- Time-multiplexed FIR filter bank for the audio path.
- One shared multiply-accumulate engine serves CHANNELS input channels and BANKS runtime-loadable coefficient sets (for example LPF/BPF/HPF).
- It replaces one-filter-per-instance duplication, sits between the codec sample deserialiser and the output mixer, and adds per-sample bank selection, loadable coefficients, saturation and overrun reporting.

Parameters:
- WORD_LENGTH, 16, sample and coefficient width (signed; coefficients are Q1.(WORD_LENGTH-1)).
- TAPS, 32, taps per filter (at least 2).
- CHANNELS, 2, independent delay lines (for example L/R).
- BANKS, 3, coefficient sets.
- CW, $clog2(CHANNELS) (min 1), channel index width.
- BW, $clog2(BANKS) (min 1), bank index width.
- TW, $clog2(TAPS), tap index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample offered.
- sample_ch  in  CW  channel of the offered sample.
- sample_in  in  WORD_LENGTH  signed sample.
- bank_en  in  BANKS  filters to run for this sample; sampled at acceptance.
- sample_ready  out  1  engine idle, sample accepted this cycle if valid.
- coef_we  in  1  coefficient write strobe.
- coef_bank  in  BW  target bank.
- coef_addr  in  TW  tap index k.
- coef_data  in  WORD_LENGTH  coefficient value.
- err_clr  in  1  clears the sticky error flags.
- out_valid  out  1  one-cycle result strobe.
- out_ch  out  CW  channel of the result.
- out_bank  out  BW  bank of the result.
- out_data  out  WORD_LENGTH  filtered sample.
- overrun  out  1  sticky: a sample was dropped.
- coef_err  out  1  sticky: a coefficient write was dropped.

Behaviour:
- Reset (async, active-low):
  - all outputs 0 except sample_ready=1;
  - delay lines, write pointers, coefficient array and accumulator cleared;
  - FSM goes to IDLE.
- FSM states: IDLE, MAC, EMIT.
  - IDLE: sample_ready=1. On sample_valid, write sample_in at wr_ptr[sample_ch] and latch ch and bank_en; wr_ptr advances modulo TAPS.
    - If the latched mask is nonzero, go to MAC on the lowest set bank.
    - If the mask is zero, only the delay-line write happens, no output, and the FSM stays in IDLE.
  - MAC: TAPS cycles, k=0..TAPS-1. acc += c[bank][k] * x[n-k], where x[n] is the newly accepted sample and x[n-k] is read circularly behind the pointer. Accumulator is cleared at the start of each bank. Then go to EMIT.
  - EMIT: one cycle. out_valid=1 with out_ch, out_bank and out_data held for that cycle.
    - Next enabled bank: go to MAC.
    - Otherwise: go to IDLE.
- Latency: with acceptance at edge E0, the j-th enabled bank (j=0..) has out_valid high in cycle E0+(j+1)*(TAPS+1). For TAPS=32 that is 33, 66, 99.
- sample_ready is low from E0+1 until the final EMIT cycle, and is high during that final EMIT cycle, so back-to-back acceptance is possible.
- Arithmetic:
  - Product width 2*WORD_LENGTH, signed.
  - Accumulator width 2*WORD_LENGTH+TW; it never wraps.
  - Result is acc arithmetically shifted right by WORD_LENGTH-1 (truncation toward minus infinity).
  - Saturate to [0x8000, 0x7FFF] for WORD_LENGTH=16.
- Samples not yet written since reset read as 0.
- sample_valid while sample_ready=0: sample dropped, no state change, overrun set.
- Coefficient writes:
  - coef_we while sample_ready=1: written at the clock edge. If it coincides with sample acceptance, the new coefficient is used for that sample.
  - coef_we while sample_ready=0: dropped, coef_err set.
  - coef_bank >= BANKS: ignored.
- err_clr clears both sticky flags. An error event in the same cycle as err_clr wins (flag set).
- sample_ch >= CHANNELS: sample dropped, overrun set.
- reset asserted mid-MAC or mid-EMIT: the operation is aborted immediately and no partial result is emitted.

Test Plan:
- Impulse response:
  - Stimulus: bank0 c[0]=0x4000, c[1]=0x2000, rest 0; ch0 samples 0x1000, 0x0000, 0x0000 with bank_en=001.
  - Required: out_data 0x0800, 0x0400, 0x0000 with out_bank=0, each at acceptance+33.
- Saturation:
  - Stimulus: bank1 all taps 0x7FFF; 32 samples of 0x7FFF, then 32 samples of 0x8000.
  - Required: final outputs 0x7FFF and 0x8000, with no wrap.
- Channel isolation:
  - Stimulus: impulse 0x1000 on ch0, then zeros on ch1.
  - Required: every ch1 output is 0x0000; a later ch0 zero sample yields the c[1] term.
- Bank mask:
  - Stimulus: bank_en=101.
  - Required: two outputs, out_bank 0 at +33 and 2 at +66, with sample_ready high in the +66 cycle. bank_en=000 gives no out_valid and sample_ready stays 1.
- Overrun and coef_err:
  - Stimulus: sample_valid and coef_we at acceptance+5.
  - Required: both dropped, overrun=1 and coef_err=1, the result is unchanged, and err_clr returns both flags to 0.
- Reset mid-MAC:
  - Stimulus: assert reset at acceptance+10.
  - Required: out_valid=0, sample_ready=1 and coefficients 0 immediately; a fresh load and impulse reproduces the first scenario exactly.
